multiply_divide_unit: RTL and testbench
=======================================

MULTIPLY_DIVIDE_UNIT -- requirements
Module: multiply_divide_unit

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 32 bits (int_t).
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request valid from EX stage; qualified by operator.
REQ-005 operator  input  3  enum: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
REQ-006 operand1  input  32  rs value: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 operand2  input  32  rt value: multiplier or divisor.
REQ-008 flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 busy  output  1  high while a multiply/divide is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 States SHALL be IDLE, RUN, FINISH; busy SHALL equal (state != IDLE), combinationally.
REQ-013 A request SHALL be accepted only when start=1, busy=0 and flush=0; otherwise it is ignored, with no effect.
REQ-014 An accepted MTHI/MTLO SHALL write operand1 into hi/lo at that edge; state SHALL remain IDLE; the new value SHALL be visible the next cycle.
REQ-015 An accepted MULT/MULTU/DIV/DIVU SHALL latch operand magnitudes, signedness, operand signs and op type, clear the 5-bit iteration counter, and enter RUN.
REQ-016 RUN SHALL perform one radix-2 step per cycle for exactly 32 cycles; multiply uses shift-add into a 64-bit accumulator, divide uses restoring shift-subtract.
REQ-017 After the 32nd step (counter == 31), the state SHALL go to FINISH; FINISH SHALL apply sign correction, write hi/lo, and return to IDLE.
REQ-018 Latency: accept at edge T; busy SHALL be high for cycles T+1..T+33; the new hi/lo SHALL be visible from T+34; a new request SHALL be acceptable at edge T+34.
REQ-019 hi/lo SHALL hold their previous values throughout RUN/FINISH; no partial results SHALL be exposed.
REQ-020 MULT/MULTU: {hi,lo} SHALL be the 64-bit signed/unsigned product; for signed, the magnitude product is negated iff operand signs differ.
REQ-021 DIV/DIVU: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder with the sign of the dividend.
REQ-022 Divide by zero SHALL NOT trap: DIVU gives lo=0xFFFFFFFF, hi=operand1; DIV gives hi=operand1, lo=0xFFFFFFFF if operand1>=0, else 0x00000001.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 flush=1 SHALL force the state to IDLE at the next edge from any state, including FINISH, leaving hi/lo unchanged.
REQ-025 flush and start in the same cycle: flush SHALL win and nothing is accepted.
REQ-026 start while busy SHALL be ignored; the requester holds start and stalls until busy=0.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, busy=0, hi=0, lo=0, counter=0, regardless of clock, including mid-RUN.
REQ-028 After reset deassertion, a request SHALL be acceptable on the first rising edge.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 33 cycles; hi=0xFFFFFFFE, lo=0x00000001 at T+34.
REQ-030 MULT 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 MTHI 0x12345678 while idle -> hi=0x12345678 next cycle, busy stays 0; MTLO issued while busy -> lo unchanged.
REQ-033 MULT accepted, flush asserted at T+10 -> busy=0 at T+11, hi/lo keep prior values; new DIVU accepted at T+11 completes normally.
REQ-034 reset pulsed asynchronously mid-RUN (between edges) -> busy, hi, lo read 0 before the next clock edge.

Source files
------------

// File: rtl/multiply_divide_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one radix-2 step per cycle, 32 steps per op,
// plus a sign-correction cycle; MTHI/MTLO write the architectural registers directly.
module multiply_divide_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  operator,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef logic [31:0] int_t;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  int_t        b_q, b_d;
  logic        is_div_q, is_div_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  int_t        hi_q, hi_d;
  int_t        lo_q, lo_d;

  mdu_op_e     op;
  logic        accept;
  logic        signed_op;
  logic        s1, s2;
  int_t        mag1, mag2;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;
  logic [63:0] div_next;
  logic [63:0] prod_neg;

  assign op     = mdu_op_e'(operator);
  assign busy   = (state_q != StIdle);
  assign accept = start & ~busy & ~flush;
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Operands are reduced to magnitudes up front; signs are re-applied in the finish cycle.
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign s1        = signed_op & operand1[31];
  assign s2        = signed_op & operand2[31];
  assign mag1      = s1 ? -operand1 : operand1;
  assign mag2      = s2 ? -operand2 : operand2;

  // Shift-add multiply: low half of acc holds the remaining multiplier bits.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide: high half is the partial remainder, low half shifts dividend into quotient.
  assign rem_sh   = acc_q[63:31];
  assign diff     = rem_sh - {1'b0, b_q};
  assign ge       = ~diff[32];
  assign div_next = {(ge ? diff[31:0] : rem_sh[31:0]), acc_q[30:0], ge};

  assign prod_neg = -acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            MDU_MTHI: hi_d = operand1;
            MDU_MTLO: lo_d = operand1;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              acc_d    = {32'd0, mag1};
              b_d      = mag2;
              is_div_d = (op == MDU_DIV) || (op == MDU_DIVU);
              sign1_d  = s1;
              sign2_d  = s2;
              cnt_d    = 5'd0;
              state_d  = StRun;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFinish;
      end
      StFinish: begin
        if (is_div_q) begin
          lo_d = (sign1_q ^ sign2_q) ? -acc_q[31:0] : acc_q[31:0];
          hi_d = sign1_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = (sign1_q ^ sign2_q) ? prod_neg : acc_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush beats everything, including the result write in the finish cycle.
    if (flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      is_div_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed-vector bench for multiply_divide_unit: latency, results, MTHI/MTLO, flush and reset.
module tb_multiply_divide_unit;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  operator = 3'd0;
  logic [31:0] operand1 = 32'd0;
  logic [31:0] operand2 = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  multiply_divide_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .operator (operator),
    .operand1 (operand1),
    .operand2 (operand2),
    .flush    (flush),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  // Issue one request and wait (bounded) for busy to drop; returns the busy cycle count.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clock);
    start = 1'b1; operator = op; operand1 = a; operand2 = b;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %h want 0", busy); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL multu_latency got %0d want 33", n); end
    vectors++; if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", lo); end
    run_op(OpMult, 32'hFFFFFFFD, 32'h00000007, n);
    vectors++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      miscompares++; $display("FAIL mult_neg got %h_%h want ffffffff_ffffffeb", hi, lo); end
    run_op(OpMult, 32'hFFFFFFFC, 32'hFFFFFFFB, n);
    vectors++; if ({hi, lo} !== 64'd20) begin
      miscompares++; $display("FAIL mult_negneg got %h_%h want 0_14", hi, lo); end
    run_op(OpMultu, 32'h00010000, 32'h00010000, n);
    vectors++; if ({hi, lo} !== 64'h00000001_00000000) begin
      miscompares++; $display("FAIL multu_carry got %h_%h want 1_0", hi, lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(OpDiv, 32'hFFFFFFF9, 32'd2, n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL div_latency got %0d want 33", n); end
    vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run_op(OpDiv, 32'd7, 32'hFFFFFFFE, n);
    vectors++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin
      miscompares++; $display("FAIL div_posneg got %h_%h want 1_fffffffd", hi, lo); end
    run_op(OpDivu, 32'd100, 32'd7, n);
    vectors++; if ({hi, lo} !== 64'h00000002_0000000E) begin
      miscompares++; $display("FAIL divu_small got %h_%h want 2_e", hi, lo); end
    run_op(OpDivu, 32'hFFFFFFFF, 32'h10, n);
    vectors++; if ({hi, lo} !== 64'h0000000F_0FFFFFFF) begin
      miscompares++; $display("FAIL divu_big got %h_%h want f_0fffffff", hi, lo); end
  endtask

  task automatic test_div_corner();
    int n;
    run_op(OpDivu, 32'd5, 32'd0, n);
    vectors++; if ({hi, lo} !== 64'h00000005_FFFFFFFF) begin
      miscompares++; $display("FAIL divu_zero got %h_%h want 5_ffffffff", hi, lo); end
    run_op(OpDiv, 32'hFFFFFFF8, 32'd0, n);
    vectors++; if ({hi, lo} !== 64'hFFFFFFF8_00000001) begin
      miscompares++; $display("FAIL div_zero_neg got %h_%h want fffffff8_1", hi, lo); end
    run_op(OpDiv, 32'd8, 32'd0, n);
    vectors++; if ({hi, lo} !== 64'h00000008_FFFFFFFF) begin
      miscompares++; $display("FAIL div_zero_pos got %h_%h want 8_ffffffff", hi, lo); end
    run_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, n);
    vectors++; if ({hi, lo} !== 64'h00000000_80000000) begin
      miscompares++; $display("FAIL div_overflow got %h_%h want 0_80000000", hi, lo); end
  endtask

  task automatic test_move();
    int n;
    run_op(OpMthi, 32'h12345678, 32'd0, n);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL mthi_busy got %0d want 0", n); end
    vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    run_op(OpMtlo, 32'hCAFEF00D, 32'd0, n);
    vectors++; if (lo !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
    // MTLO attempted while a MULTU is running must be dropped.
    @(negedge clock);
    start = 1'b1; operator = OpMultu; operand1 = 32'd3; operand2 = 32'd5;
    @(posedge clock); #1;
    operator = OpMtlo; operand1 = 32'hDEADBEEF;
    repeat (3) begin @(posedge clock); #1; end
    start = 1'b0;
    vectors++; if (lo !== 32'hCAFEF00D) begin miscompares++; $display("FAIL hold_lo_midrun got %h want cafef00d", lo); end
    n = 0;
    while (busy && n < 100) begin n++; @(posedge clock); #1; end
    vectors++; if ({hi, lo} !== 64'd15) begin
      miscompares++; $display("FAIL mtlo_while_busy got %h_%h want 0_f", hi, lo); end
  endtask

  task automatic test_flush();
    int n;
    @(negedge clock);
    start = 1'b1; operator = OpMult; operand1 = 32'd3; operand2 = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %h want 0", busy); end
    vectors++; if ({hi, lo} !== 64'd15) begin
      miscompares++; $display("FAIL flush_hold got %h_%h want 0_f", hi, lo); end
    run_op(OpDivu, 32'd20, 32'd3, n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL post_flush_latency got %0d want 33", n); end
    vectors++; if ({hi, lo} !== 64'h00000002_00000006) begin
      miscompares++; $display("FAIL post_flush_divu got %h_%h want 2_6", hi, lo); end
    // Flush in the finish cycle suppresses the result write.
    @(negedge clock);
    start = 1'b1; operator = OpMultu; operand1 = 32'd9; operand2 = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (32) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_finish_busy got %h want 0", busy); end
    vectors++; if ({hi, lo} !== 64'h00000002_00000006) begin
      miscompares++; $display("FAIL flush_finish_hold got %h_%h want 2_6", hi, lo); end
    // Flush together with start: nothing accepted.
    @(negedge clock);
    start = 1'b1; flush = 1'b1; operator = OpMthi; operand1 = 32'hABCD0000;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL flush_start_hi got %h want 2", hi); end
    @(negedge clock);
    start = 1'b1; flush = 1'b1; operator = OpDivu; operand1 = 32'd9; operand2 = 32'd3;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_start_busy got %h want 0", busy); end
  endtask

  task automatic test_async_reset();
    int n;
    run_op(OpMthi, 32'h5555AAAA, 32'd0, n);
    @(negedge clock);
    start = 1'b1; operator = OpMult; operand1 = 32'd11; operand2 = 32'd13;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_busy got %h want 0", busy); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL async_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL async_lo got %h want 0", lo); end
    // Request presented with reset release is taken on the very next edge.
    reset = 1'b0;
    start = 1'b1; operator = OpMultu; operand1 = 32'd6; operand2 = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL post_reset_accept got %h want 1", busy); end
    n = 1;
    while (busy && n < 100) begin n++; @(posedge clock); #1; end
    vectors++; if (n !== 34) begin miscompares++; $display("FAIL post_reset_latency got %0d want 34", n); end
    vectors++; if ({hi, lo} !== 64'd42) begin
      miscompares++; $display("FAIL post_reset_result got %h_%h want 0_2a", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_move();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
